// File: rtl/entrada_bcd_gray.sv
// Two-digit BCD entry (tens then units) assembled into a 0-15 binary value plus its Gray code.
// All outputs registered, one edge after the strobe; single-digit capture, no backpressure.
module entrada_bcd_gray #(
  parameter int TIMEOUT_CICLOS = 50_000_000,
  parameter int ANCHO_TIMER    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digito_in,
  input  logic       digito_valido,
  input  logic       borrar,
  output logic [3:0] bin,
  output logic [3:0] gray,
  output logic       valido,
  output logic       error,
  output logic       timeout,
  output logic       esperando_unidad,
  output logic [3:0] decena_actual
);

  typedef enum logic [1:0] {
    E_DECENA = 2'b00,
    E_UNIDAD = 2'b01
  } estado_t;

  localparam logic [ANCHO_TIMER-1:0] T_MAX = ANCHO_TIMER'(TIMEOUT_CICLOS - 1);
  localparam logic [ANCHO_TIMER-1:0] T_UNO = ANCHO_TIMER'(1);

  estado_t               estado_q, estado_d;
  logic [ANCHO_TIMER-1:0] timer_q, timer_d;
  logic [3:0]            decena_d, bin_d, gray_d;
  logic                  valido_d, error_d, timeout_d;
  logic [4:0]            v;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q         <= E_DECENA;
      timer_q          <= '0;
      decena_actual    <= 4'd0;
      bin              <= 4'd0;
      gray             <= 4'd0;
      valido           <= 1'b0;
      error            <= 1'b0;
      timeout          <= 1'b0;
      esperando_unidad <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      timer_q          <= timer_d;
      decena_actual    <= decena_d;
      bin              <= bin_d;
      gray             <= gray_d;
      valido           <= valido_d;
      error            <= error_d;
      timeout          <= timeout_d;
      esperando_unidad <= (estado_d == E_UNIDAD);
    end
  end

  always_comb begin
    estado_d  = estado_q;
    timer_d   = timer_q;
    decena_d  = decena_actual;
    bin_d     = bin;
    gray_d    = gray;
    valido_d  = 1'b0;
    error_d   = 1'b0;
    timeout_d = 1'b0;
    v         = ({1'b0, decena_actual} * 5'd10) + {1'b0, digito_in};

    if (borrar) begin
      estado_d = E_DECENA;
      timer_d  = '0;
      decena_d = 4'd0;
      bin_d    = 4'd0;
      gray_d   = 4'd0;
    end else begin
      case (estado_q)
        E_DECENA: begin
          timer_d = '0;
          if (digito_valido) begin
            if (digito_in <= 4'd1) begin
              decena_d = digito_in;
              estado_d = E_UNIDAD;
            end else begin
              error_d = 1'b1;
            end
          end
        end
        E_UNIDAD: begin
          // A strobe wins over expiry, even in the expiry cycle itself.
          if (digito_valido) begin
            estado_d = E_DECENA;
            decena_d = 4'd0;
            timer_d  = '0;
            if (digito_in > 4'd9 || v > 5'd15) begin
              error_d = 1'b1;
            end else begin
              bin_d    = v[3:0];
              gray_d   = v[3:0] ^ (v[3:0] >> 1);
              valido_d = 1'b1;
            end
          end else if (timer_q == T_MAX) begin
            timeout_d = 1'b1;
            estado_d  = E_DECENA;
            decena_d  = 4'd0;
            timer_d   = '0;
          end else begin
            timer_d = timer_q + T_UNO;
          end
        end
        default: begin
          estado_d = E_DECENA;
          decena_d = 4'd0;
          timer_d  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_entrada_bcd_gray.sv
// Directed bench for entrada_bcd_gray with a short timeout.
module tb_entrada_bcd_gray;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digito_in;
  logic       digito_valido;
  logic       borrar;
  logic [3:0] bin;
  logic [3:0] gray;
  logic       valido;
  logic       error;
  logic       timeout;
  logic       esperando_unidad;
  logic [3:0] decena_actual;

  int checks = 0;
  int errors = 0;

  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  entrada_bcd_gray #(.TIMEOUT_CICLOS(8), .ANCHO_TIMER(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .digito_in        (digito_in),
    .digito_valido    (digito_valido),
    .borrar           (borrar),
    .bin              (bin),
    .gray             (gray),
    .valido           (valido),
    .error            (error),
    .timeout          (timeout),
    .esperando_unidad (esperando_unidad),
    .decena_actual    (decena_actual)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then leave them idle just after the edge.
  task automatic step(input logic vld, input logic [3:0] d, input logic clr, input logic r);
    @(negedge clk);
    digito_valido = vld;
    digito_in     = d;
    borrar        = clr;
    rst           = r;
    @(posedge clk);
    #1;
    digito_valido = 1'b0;
    borrar        = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic check_pulses(input string tag, input logic v, input logic e, input logic t);
    check({tag, " valido"},  8'(valido),  8'(v));
    check({tag, " error"},   8'(error),   8'(e));
    check({tag, " timeout"}, 8'(timeout), 8'(t));
  endtask

  initial begin
    rst = 1'b1; digito_valido = 1'b0; digito_in = 4'd0; borrar = 1'b0;
    step(1'b1, 4'd1, 1'b0, 1'b1);
    step(1'b1, 4'd1, 1'b0, 1'b1);
    check("rst bin", 8'(bin), 8'd0);
    check("rst gray", 8'(gray), 8'd0);
    check("rst esp", 8'(esperando_unidad), 8'd0);
    check("rst decena", 8'(decena_actual), 8'd0);
    check_pulses("rst", 1'b0, 1'b0, 1'b0);

    strobe(4'd1);
    check("13 esp", 8'(esperando_unidad), 8'd1);
    check("13 decena", 8'(decena_actual), 8'd1);
    check_pulses("13 tens", 1'b0, 1'b0, 1'b0);
    strobe(4'd3);
    check("13 bin", 8'(bin), 8'd13);
    check("13 gray", 8'(gray), 8'b1011);
    check("13 esp after", 8'(esperando_unidad), 8'd0);
    check_pulses("13 units", 1'b1, 1'b0, 1'b0);
    idle();
    check_pulses("13 idle", 1'b0, 1'b0, 1'b0);
    check("13 hold", 8'(bin), 8'd13);

    strobe(4'd0); strobe(4'd9);
    check("09 bin", 8'(bin), 8'd9);
    check("09 gray", 8'(gray), 8'b1101);
    check_pulses("09", 1'b1, 1'b0, 1'b0);

    strobe(4'd1); strobe(4'd6);
    check_pulses("16", 1'b0, 1'b1, 1'b0);
    check("16 bin", 8'(bin), 8'd9);
    check("16 gray", 8'(gray), 8'b1101);
    check("16 esp", 8'(esperando_unidad), 8'd0);
    idle();
    check("16 err clear", 8'(error), 8'd0);

    strobe(4'd2);
    check_pulses("tens 2", 1'b0, 1'b1, 1'b0);
    check("tens 2 esp", 8'(esperando_unidad), 8'd0);
    strobe(4'd1); strobe(4'hA);
    check_pulses("1A", 1'b0, 1'b1, 1'b0);
    check("1A esp", 8'(esperando_unidad), 8'd0);
    check("1A bin", 8'(bin), 8'd9);

    strobe(4'd1);
    for (int i = 1; i < 8; i++) begin
      idle();
      check("to wait timeout", 8'(timeout), 8'd0);
      check("to wait esp", 8'(esperando_unidad), 8'd1);
    end
    idle();
    check("to pulse", 8'(timeout), 8'd1);
    check("to esp", 8'(esperando_unidad), 8'd0);
    check("to decena", 8'(decena_actual), 8'd0);
    check("to bin", 8'(bin), 8'd9);
    idle();
    check("to clear", 8'(timeout), 8'd0);

    strobe(4'd1);
    for (int i = 1; i < 8; i++) idle();
    strobe(4'd5);
    check("15 bin", 8'(bin), 8'd15);
    check("15 gray", 8'(gray), 8'b1000);
    check_pulses("15 expiry", 1'b1, 1'b0, 1'b0);
    idle();
    check("15 no late timeout", 8'(timeout), 8'd0);

    strobe(4'd1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("clr bin", 8'(bin), 8'd0);
    check("clr gray", 8'(gray), 8'd0);
    check("clr esp", 8'(esperando_unidad), 8'd0);
    check("clr decena", 8'(decena_actual), 8'd0);
    check_pulses("clr", 1'b0, 1'b0, 1'b0);

    strobe(4'd1); strobe(4'd2);
    check("12 bin", 8'(bin), 8'd12);
    strobe(4'd1);
    step(1'b1, 4'd3, 1'b1, 1'b0);
    check("clr over strobe bin", 8'(bin), 8'd0);
    check("clr over strobe valido", 8'(valido), 8'd0);

    strobe(4'd1); strobe(4'd2);
    strobe(4'd1);
    step(1'b1, 4'd4, 1'b0, 1'b1);
    check("rst+strobe bin", 8'(bin), 8'd0);
    check("rst+strobe gray", 8'(gray), 8'd0);
    check("rst+strobe esp", 8'(esperando_unidad), 8'd0);
    check("rst+strobe decena", 8'(decena_actual), 8'd0);
    check_pulses("rst+strobe", 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 2; t++) begin
      for (int u = 0; u < 10; u++) begin
        if (t * 10 + u <= 15) begin
          strobe(4'(t));
          strobe(4'(u));
          check($sformatf("sweep bin %0d%0d", t, u), 8'(bin), 8'(t * 10 + u));
          check($sformatf("sweep gray %0d%0d", t, u), 8'(gray), 8'(gray_tab[t * 10 + u]));
          check($sformatf("sweep valido %0d%0d", t, u), 8'(valido), 8'd1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
